// File: rtl/rx_memory_control.sv
// Receive-side VRAM writer: rebuilds {R,G,B} pixels from the R/B/G payload byte
// order of one video segment and filters duplicate, damaged or illegal copies.
module rx_memory_control #(
   parameter int SEG_BYTES   = 1080,
   parameter int PIX_PER_SEG = 360,
   parameter int SEG_W       = 12,
   parameter int MAX_SEG     = 2304,
   parameter int ADDR_W      = 20
) (
   input  logic              clk125MHz,
   input  logic              rst,
   input  logic              pl_sop,
   input  logic [SEG_W-1:0]  segment_num,
   input  logic [7:0]        txid,
   input  logic              pl_valid,
   input  logic [7:0]        pl_data,
   input  logic              pl_eop,
   input  logic              pl_err,
   output logic              vram_we,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [23:0]       vram_din,
   output logic              seg_done,
   output logic              seg_dup,
   output logic              seg_err,
   output logic [7:0]        last_id,
   output logic              busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RECV = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   localparam logic [10:0]       SEG_BYTES_C = 11'(SEG_BYTES);
   localparam logic [10:0]       BYTE_SAT_C  = 11'(SEG_BYTES + 1);
   localparam logic [SEG_W-1:0]  MAX_SEG_C   = SEG_W'(MAX_SEG);
   localparam logic [ADDR_W-1:0] PIX_C       = ADDR_W'(PIX_PER_SEG);
   localparam logic [ADDR_W-1:0] ONE_A       = ADDR_W'(1);

   logic [1:0]        state_r;
   logic [SEG_W-1:0]  seg_r;
   logic [7:0]        id_r;
   logic [ADDR_W-1:0] base_r;
   logic [10:0]       byte_cnt_r;
   logic [1:0]        phase_r;
   logic [ADDR_W-1:0] pix_idx_r;
   logic [7:0]        r_r;
   logic [7:0]        b_r;
   logic              ovf_r;
   logic              bad_r;
   logic              last_ok_r;
   logic [SEG_W-1:0]  last_seg_r;

   logic [1:0]        state_n_s;
   logic [ADDR_W-1:0] base_n_s;
   logic              abort_s;
   logic              illegal_s;
   logic              dup_s;
   logic              data_s;
   logic              eop_recv_s;
   logic              eop_drop_s;
   logic              room_s;
   logic              pix_s;
   logic              accept_s;

   // Decode strobes into byte/pixel/segment events and choose the next state
   always_comb begin
      state_n_s  = state_r;
      abort_s    = pl_sop && (state_r != ST_IDLE);
      illegal_s  = (segment_num >= MAX_SEG_C);
      dup_s      = last_ok_r && (segment_num == last_seg_r);
      // a byte sharing its cycle with sop or eop is never data
      data_s     = pl_valid && !pl_sop && !pl_eop && (state_r == ST_RECV);
      eop_recv_s = pl_eop && !pl_sop && (state_r == ST_RECV);
      eop_drop_s = pl_eop && !pl_sop && (state_r == ST_DROP);
      room_s     = (byte_cnt_r < SEG_BYTES_C);
      pix_s      = data_s && room_s && (phase_r == 2'd2);
      accept_s   = eop_recv_s && !pl_err && (byte_cnt_r == SEG_BYTES_C) && !ovf_r;
      base_n_s   = ADDR_W'(segment_num) * PIX_C;
      case (state_r)
         ST_IDLE, ST_RECV, ST_DROP: begin
            if (pl_sop) begin
               if (illegal_s || dup_s) begin
                  state_n_s = ST_DROP;
               end else begin
                  state_n_s = ST_RECV;
               end
            end else if (eop_recv_s || eop_drop_s) begin
               state_n_s = ST_IDLE;
            end else begin
               state_n_s = state_r;
            end
         end
         default: state_n_s = ST_IDLE;
      endcase
   end

   // State register and registered status pulses
   always_ff @(posedge clk125MHz) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         busy     <= 1'b0;
         seg_done <= 1'b0;
         seg_dup  <= 1'b0;
         seg_err  <= 1'b0;
      end else begin
         state_r  <= state_n_s;
         busy     <= (state_n_s != ST_IDLE);
         seg_done <= accept_s;
         seg_dup  <= eop_drop_s && !bad_r;
         seg_err  <= abort_s || (eop_recv_s && !accept_s) || (eop_drop_s && bad_r);
      end
   end

   // Per-copy context captured at the header strobe
   always_ff @(posedge clk125MHz) begin
      if (rst) begin
         seg_r  <= {SEG_W{1'b0}};
         id_r   <= 8'd0;
         base_r <= {ADDR_W{1'b0}};
         bad_r  <= 1'b0;
      end else if (pl_sop) begin
         seg_r  <= segment_num;
         id_r   <= txid;
         base_r <= base_n_s;
         bad_r  <= illegal_s;
      end
   end

   // Byte counting and R/B/G reassembly; bytes beyond the segment length only flag overflow
   always_ff @(posedge clk125MHz) begin
      if (rst) begin
         byte_cnt_r <= 11'd0;
         phase_r    <= 2'd0;
         pix_idx_r  <= {ADDR_W{1'b0}};
         r_r        <= 8'd0;
         b_r        <= 8'd0;
         ovf_r      <= 1'b0;
      end else if (pl_sop) begin
         byte_cnt_r <= 11'd0;
         phase_r    <= 2'd0;
         pix_idx_r  <= {ADDR_W{1'b0}};
         ovf_r      <= 1'b0;
      end else if (data_s) begin
         if (byte_cnt_r != BYTE_SAT_C) begin
            byte_cnt_r <= byte_cnt_r + 11'd1;
         end
         if (!room_s) begin
            ovf_r <= 1'b1;
         end else begin
            case (phase_r)
               2'd0: begin
                  r_r     <= pl_data;
                  phase_r <= 2'd1;
               end
               2'd1: begin
                  b_r     <= pl_data;
                  phase_r <= 2'd2;
               end
               2'd2: begin
                  phase_r   <= 2'd0;
                  pix_idx_r <= pix_idx_r + ONE_A;
               end
               default: phase_r <= 2'd0;
            endcase
         end
      end
   end

   // VRAM write port; G arrives last so it is taken straight from the bus
   always_ff @(posedge clk125MHz) begin
      if (rst) begin
         vram_we   <= 1'b0;
         vram_addr <= {ADDR_W{1'b0}};
         vram_din  <= 24'd0;
      end else begin
         vram_we <= pix_s;
         if (pix_s) begin
            vram_addr <= base_r + pix_idx_r;
            vram_din  <= {r_r, pl_data, b_r};
         end
      end
   end

   // Record of the last intact copy, used for duplicate suppression
   always_ff @(posedge clk125MHz) begin
      if (rst) begin
         last_ok_r  <= 1'b0;
         last_seg_r <= {SEG_W{1'b0}};
         last_id    <= 8'd0;
      end else if (accept_s) begin
         last_ok_r  <= 1'b1;
         last_seg_r <= seg_r;
         last_id    <= id_r;
      end
   end

endmodule

// File: tb/tb_rx_memory_control.sv
// Bench for rx_memory_control: a transaction-level model predicts every pixel write,
// status pulse, busy and last_id per cycle; literal checks pin the directed cases.
module tb_rx_memory_control;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pl_sop = 1'b0;
   logic [11:0] segment_num = 12'd0;
   logic [7:0]  txid = 8'd0;
   logic        pl_valid = 1'b0;
   logic [7:0]  pl_data = 8'd0;
   logic        pl_eop = 1'b0;
   logic        pl_err = 1'b0;
   logic        vram_we;
   logic [19:0] vram_addr;
   logic [23:0] vram_din;
   logic        seg_done;
   logic        seg_dup;
   logic        seg_err;
   logic [7:0]  last_id;
   logic        busy;

   rx_memory_control dut (
      .clk125MHz(clk), .rst(rst), .pl_sop(pl_sop), .segment_num(segment_num),
      .txid(txid), .pl_valid(pl_valid), .pl_data(pl_data), .pl_eop(pl_eop),
      .pl_err(pl_err), .vram_we(vram_we), .vram_addr(vram_addr), .vram_din(vram_din),
      .seg_done(seg_done), .seg_dup(seg_dup), .seg_err(seg_err), .last_id(last_id),
      .busy(busy)
   );

   always #4 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct { int cyc; logic [19:0] addr; logic [23:0] din; } wr_t;
   typedef struct { int cyc; int kind; } ev_t;   // kind 1 done, 2 dup, 3 err
   wr_t wq[$];
   ev_t eq[$];

   // model state
   bit         m_open = 1'b0;
   int         m_kind = 0;     // 0 receive, 1 duplicate, 2 illegal
   int         m_seg = 0;
   int         m_id = 0;
   int         m_n = 0;
   int         m_base = 0;
   logic [7:0] m_px [3];
   bit         m_last_ok = 1'b0;
   int         m_last_seg = 0;
   int         m_last_id = 0;
   bit         busy_exp = 1'b0;
   int         last_id_exp = 0;
   bit         chk_en = 1'b0;

   // window statistics observed from the DUT
   int          w_cnt = 0;
   logic [19:0] w_first_addr = 20'd0;
   logic [23:0] w_first_din = 24'd0;
   logic [19:0] w_last_addr = 20'd0;
   int          n_done = 0;
   int          n_dup = 0;
   int          n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h cycle=%0d", nm, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input int kind);
      ev_t e;
      e.cyc = cyc + 1;
      e.kind = kind;
      eq.push_back(e);
   endtask

   task automatic push_wr(input int addr, input logic [23:0] din);
      wr_t w;
      w.cyc = cyc + 1;
      w.addr = 20'(addr);
      w.din = din;
      wq.push_back(w);
   endtask

   // one input cycle; the model follows the segment rules on the same inputs
   task automatic drive(input bit sop, input int sn, input int id, input bit v,
                        input logic [7:0] d, input bit eop, input bit err);
      @(posedge clk);
      #1;
      busy_exp = m_open;
      last_id_exp = m_last_id;
      rst = 1'b0;
      pl_sop = sop;
      segment_num = 12'(sn);
      txid = 8'(id);
      pl_valid = v;
      pl_data = d;
      pl_eop = eop;
      pl_err = err;
      if (sop) begin
         if (m_open) push_ev(3);
         m_open = 1'b1;
         m_seg = sn;
         m_id = id;
         m_n = 0;
         m_base = (sn * 360) % (1 << 20);
         if (sn >= 2304) m_kind = 2;
         else if (m_last_ok && sn == m_last_seg) m_kind = 1;
         else m_kind = 0;
      end else if (eop) begin
         if (m_open) begin
            if (m_kind == 0) begin
               if (!err && m_n == 1080) begin
                  push_ev(1);
                  m_last_ok = 1'b1;
                  m_last_seg = m_seg;
                  m_last_id = m_id;
               end else begin
                  push_ev(3);
               end
            end else if (m_kind == 1) begin
               push_ev(2);
            end else begin
               push_ev(3);
            end
            m_open = 1'b0;
         end
      end else if (v && m_open && m_kind == 0) begin
         if (m_n < 1080) begin
            m_px[m_n % 3] = d;
            if (m_n % 3 == 2) push_wr(m_base + m_n / 3, {m_px[0], d, m_px[1]});
         end
         m_n++;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      busy_exp = m_open;
      last_id_exp = m_last_id;
      rst = 1'b1;
      pl_sop = 1'b0;
      pl_valid = 1'b0;
      pl_eop = 1'b0;
      pl_err = 1'b0;
      m_open = 1'b0;
      m_last_ok = 1'b0;
      m_last_seg = 0;
      m_last_id = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 8'($urandom), 1'b0, 1'b0);
   endtask

   task automatic send_sop(input int sn, input int id, input bit noisy);
      drive(1'b1, sn, id, noisy ? 1'($urandom) : 1'b0, 8'($urandom), 1'b0, 1'b0);
   endtask

   task automatic send_bytes(input int nb, input int off, input int vpct);
      int k = 0;
      while (k < nb) begin
         bit v;
         v = (vpct >= 100) ? 1'b1 : ($urandom_range(0, 99) < vpct);
         drive(1'b0, 0, 0, v, v ? 8'((k + off) & 255) : 8'($urandom), 1'b0, 1'b0);
         if (v) k++;
      end
   endtask

   task automatic send_eop(input bit err, input bit noisy);
      drive(1'b0, 0, 0, noisy ? 1'($urandom) : 1'b0, 8'($urandom), 1'b1, err);
   endtask

   task automatic send_seg(input int sn, input int id, input int nb, input bit err, input int off);
      send_sop(sn, id, 1'b0);
      send_bytes(nb, off, 100);
      send_eop(err, 1'b0);
   endtask

   task automatic win_clear();
      w_cnt = 0;
      n_done = 0;
      n_dup = 0;
      n_err = 0;
   endtask

   // compare process: every output against the model on every cycle
   always @(negedge clk) begin
      bit exp_we;
      int exp_k;
      if (chk_en) begin
         exp_we = (wq.size() > 0) && (wq[0].cyc == cyc);
         chk("vram_we", vram_we, exp_we);
         if (exp_we) begin
            chk("vram_addr", vram_addr, wq[0].addr);
            chk("vram_din", vram_din, wq[0].din);
            wq.delete(0);
         end
         exp_k = 0;
         if (eq.size() > 0 && eq[0].cyc == cyc) begin
            exp_k = eq[0].kind;
            eq.delete(0);
         end
         chk("seg_done", seg_done, exp_k == 1);
         chk("seg_dup", seg_dup, exp_k == 2);
         chk("seg_err", seg_err, exp_k == 3);
         chk("busy", busy, busy_exp);
         chk("last_id", last_id, last_id_exp);
         if (vram_we) begin
            if (w_cnt == 0) begin
               w_first_addr = vram_addr;
               w_first_din = vram_din;
            end
            w_last_addr = vram_addr;
            w_cnt++;
         end
         if (seg_done) n_done++;
         if (seg_dup) n_dup++;
         if (seg_err) n_err++;
      end
   end

   always @(posedge clk) begin
      if (cyc > 90000) begin
         $display("FAIL watchdog: cycle=%0d limit=90000", cyc);
         $display("test done: total=%0d bad=%0d", total, bad + 1);
         $fatal(1, "cycle budget exhausted");
      end
   end

   initial begin
      int prev_sn;
      int sn;
      int nb;
      int lens [5] = '{1080, 1080, 1080, 1077, 1082};
      repeat (2) @(posedge clk);
      do_reset();
      @(negedge clk);
      chk("rst_vram_we", vram_we, 0);
      chk("rst_vram_addr", vram_addr, 0);
      chk("rst_vram_din", vram_din, 0);
      chk("rst_seg_done", seg_done, 0);
      chk("rst_seg_dup", seg_dup, 0);
      chk("rst_seg_err", seg_err, 0);
      chk("rst_last_id", last_id, 0);
      chk("rst_busy", busy, 0);
      chk_en = 1'b1;

      win_clear();
      send_seg(5, 1, 1080, 1'b0, 0);
      idle(3);
      chk("clean_writes", w_cnt, 360);
      chk("clean_first_addr", w_first_addr, 1800);
      chk("clean_first_din", w_first_din, 32'h000201);
      chk("clean_last_addr", w_last_addr, 2159);
      chk("clean_done", n_done, 1);
      chk("clean_last_id", last_id, 1);

      win_clear();
      send_seg(5, 2, 1080, 1'b0, 0);
      idle(3);
      chk("dup_writes", w_cnt, 0);
      chk("dup_pulse", n_dup, 1);
      chk("dup_last_id", last_id, 1);

      win_clear();
      send_seg(7, 1, 1080, 1'b1, 3);
      idle(3);
      chk("corrupt_err", n_err, 1);
      chk("corrupt_done", n_done, 0);
      win_clear();
      send_seg(7, 2, 1080, 1'b0, 9);
      idle(3);
      chk("retry_writes", w_cnt, 360);
      chk("retry_done", n_done, 1);
      chk("retry_last_id", last_id, 2);

      win_clear();
      send_seg(20, 1, 1079, 1'b0, 0);
      idle(3);
      chk("short_writes", w_cnt, 359);
      chk("short_err", n_err, 1);
      win_clear();
      send_seg(21, 1, 1083, 1'b0, 0);
      idle(3);
      chk("long_writes", w_cnt, 360);
      chk("long_err", n_err, 1);
      win_clear();
      send_seg(2304, 1, 1080, 1'b0, 0);
      idle(3);
      chk("illegal_writes", w_cnt, 0);
      chk("illegal_err", n_err, 1);

      win_clear();
      send_sop(9, 1, 1'b0);
      send_bytes(500, 0, 100);
      send_seg(10, 1, 1080, 1'b0, 5);
      idle(3);
      chk("abort_err", n_err, 1);
      chk("abort_done", n_done, 1);
      chk("abort_writes", w_cnt, 526);

      win_clear();
      send_sop(10, 3, 1'b0);
      send_bytes(200, 0, 100);
      do_reset();
      idle(2);
      send_seg(10, 4, 1080, 1'b0, 7);
      idle(3);
      chk("reset_done", n_done, 1);
      chk("reset_dup", n_dup, 0);
      chk("reset_err", n_err, 0);
      chk("reset_writes", w_cnt, 360);
      chk("reset_last_id", last_id, 4);

      prev_sn = 10;
      for (int s = 0; s < 20; s++) begin
         sn = ($urandom_range(0, 3) == 0) ? prev_sn : $urandom_range(0, 2310);
         nb = lens[$urandom_range(0, 4)];
         send_sop(sn, s + 1, 1'b1);
         send_bytes(nb, $urandom_range(0, 255), 60);
         send_eop($urandom_range(0, 9) == 0, 1'b1);
         prev_sn = sn;
      end
      idle(4);
      chk("writes_pending", wq.size(), 0);
      chk("events_pending", eq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rx_memory_control.md
# rx_memory_control

Receive-side counterpart of the transmit memory path. Takes de-framed Ethernet payload bytes for one video segment in the `clk125MHz` domain, reassembles the R/B/G byte interleave into 24-bit pixels, and drives the write port of the receive VRAM. Redundant copies of a segment (txid ≥ 2) are dropped once a copy has arrived intact. Only intact copies mark a segment as received. A corrupted copy is therefore overwritten by the next copy.

## Interface
Parameters:
- `SEG_BYTES`, 1080: payload bytes per segment (multiple of 3).
- `PIX_PER_SEG`, 360: pixels per segment (= SEG_BYTES/3).
- `SEG_W`, 12: width of segment number.
- `MAX_SEG`, 2304: number of valid segments per frame; segment_num ≥ MAX_SEG is illegal.
- `ADDR_W`, 20: VRAM pixel address width.

Ports:
- `clk125MHz` in 1: Ethernet rx clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pl_sop` in 1: one-cycle header strobe; `segment_num`/`txid` valid this cycle; carries no data.
- `segment_num` in SEG_W: segment index, sampled at `pl_sop`.
- `txid` in 8: copy ID (1 = first copy), sampled at `pl_sop`, reported only.
- `pl_valid` in 1: `pl_data` valid this cycle.
- `pl_data` in 8: payload byte.
- `pl_eop` in 1: one-cycle end strobe after the last byte; no data.
- `pl_err` in 1: FCS/frame error, valid with `pl_eop`.
- `vram_we` out 1: pixel write enable.
- `vram_addr` out ADDR_W: pixel address.
- `vram_din` out 24: {R,G,B}.
- `seg_done` out 1: pulse when a segment is accepted.
- `seg_dup` out 1: pulse when a copy is discarded as a duplicate.
- `seg_err` out 1: pulse when a copy is rejected.
- `last_id` out 8: txid of the most recently accepted copy.
- `busy` out 1: high outside IDLE.

## Operation
- States are IDLE, RECV, DROP.
- **IDLE.** On `pl_sop`:
  - Latch `seg`, `id` and `base = segment_num*PIX_PER_SEG`. The product is registered and truncated to ADDR_W.
  - Clear `byte_cnt` (11 bit) and `phase` (0..2).
  - If `segment_num ≥ MAX_SEG`, go to DROP with `bad=1`.
  - Else if `last_ok && segment_num == last_seg`, go to DROP with `bad=0`.
  - Else go to RECV.
- **RECV.** Each `pl_valid` byte:
  - phase 0 latches R, phase 1 latches B, phase 2 latches G.
  - At phase 2, a pixel is written at `base + pix_idx`, then `pix_idx` increments.
  - `byte_cnt` saturates at SEG_BYTES+1.
  - Bytes arriving when `byte_cnt ≥ SEG_BYTES` are not written and set `ovf`.
- **RECV on `pl_eop`:**
  - If `!pl_err && byte_cnt == SEG_BYTES && !ovf`, accept: `last_seg<=seg`, `last_ok<=1`, `last_id<=id`, pulse `seg_done`.
  - Otherwise pulse `seg_err`; `last_ok`/`last_seg` are unchanged.
  - Return to IDLE.
- **DROP.** Bytes are ignored.
  - On `pl_eop`, pulse `seg_err` if `bad`, else `seg_dup`.
  - Return to IDLE.
- **Simultaneous events and aborts:**
  - `pl_sop` in RECV/DROP (missing eop): pulse `seg_err` for the aborted copy; the sop is processed as in IDLE the same cycle.
  - `pl_eop` in IDLE is ignored.
  - `pl_valid` with `pl_sop` or `pl_eop` in the same cycle: the byte is ignored.
- Partial pixels (phase ≠ 0 at eop) are never written.
- `rst` at any point: state IDLE; `last_ok=0`, `last_seg=0`, `last_id=0`; counters cleared; in-flight pixel discarded.

## Timing
- Reset values: `vram_we=0`, `vram_addr=0`, `vram_din=0`, `seg_done=0`, `seg_dup=0`, `seg_err=0`, `last_id=0`, `busy=0`.
- `busy` is high from the cycle after `pl_sop` until the cycle after `pl_eop`.
- All outputs are registered.
- `vram_we`/`vram_addr`/`vram_din` assert in the cycle after the third byte of a pixel is accepted, for exactly one cycle.
- `seg_done`/`seg_dup`/`seg_err` pulse for one cycle, in the cycle after `pl_eop` (or after the aborting `pl_sop`).
- `base` is ready one cycle after `pl_sop`, so the first data byte may arrive in the next cycle.
- Back-to-back bytes every cycle are supported. A full segment produces 360 writes, the last one cycle after byte 1080.
- The minimum gap from eop to the next sop is 0 cycles.

## Test plan
- **Clean segment:** sop `segment_num=5`, `txid=1`, bytes 0..1079 (`byte k = k&0xFF`), eop `err=0`. Required: 360 writes, addr 1800..2159, first `vram_din` = {00,02,01}, then `seg_done`, `last_id=1`.
- **Duplicate:** the same segment 5 resent with `txid=2`. Required: no `vram_we`, `seg_dup` pulse, `last_id` stays 1.
- **Corrupt then good:** segment 7 `txid=1` with eop `err=1` gives `seg_err`. Segment 7 `txid=2` clean then gives writes and `seg_done`, `last_id=2`.
- **Length errors:**
  - 1079 bytes: 359 writes, then `seg_err`.
  - 1083 bytes: 360 writes, then `seg_err`.
  - `segment_num=2304`: no writes, `seg_err`.
- **Abort and reset:**
  - sop mid-RECV at byte 500: `seg_err` pulse, and the new segment is received normally.
  - `rst` mid-segment, then a resend of the previously accepted segment: accepted again, since `last_ok` was cleared.
- **Stress:** `pl_valid` toggling randomly across 20 segments with zero-gap sop after eop. Required: address and data scoreboard match exactly.
